key_remap_ctrl: RTL and testbench
=================================

Name: key_remap_ctrl

Overview:
Parametrised physical-to-logical key remapping controller for the organ keyboard, the generalised successor to the fixed 8-key setting-mode logic in the top-level mode FSM. The player presses physical keys in order, and the Nth accepted key becomes logical note N. A shadow map is captured and committed atomically only when all keys are assigned. Duplicates are rejected, and esc or timeout restores nothing because the committed map was never touched. The block sits between the key debouncer and the play/learn/game datapaths and supplies the remapped pressed-key vector to them.

Parameters:
NUM_KEYS, 8, number of physical/logical keys (2..16, not required to be a power of 2)
IDX_W, $clog2(NUM_KEYS), width of one map entry
TIMEOUT_CYC, 0, sys_clk cycles without an accepted key before auto-abort; 0 disables the timeout

Ports:
sys_clk  in  1  system clock; everything is clocked on its rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a capture
abort  in  1  one-cycle pulse (esc) that cancels a capture
key_pose  in  NUM_KEYS  debounced posedge pulses, bit p = physical key p
key_pres  in  NUM_KEYS  debounced level pressed, bit p = physical key p
mapped_pres  out  NUM_KEYS  registered logical pressed vector
map_flat  out  NUM_KEYS*IDX_W  committed map; entry p at [p*IDX_W +: IDX_W]
busy  out  1  high in CAPTURE and COMMIT
progress  out  IDX_W+1  number of keys accepted in the current capture
done  out  1  one-cycle pulse when a map is committed
aborted  out  1  one-cycle pulse when a capture is cancelled (abort or timeout)
key_err  out  1  one-cycle pulse when a key press is rejected in CAPTURE

Behaviour:
- Reset (rst=1 at an edge):
  - committed map and shadow map = identity (entry p = p)
  - assigned mask = 0, timer = 0, state = IDLE
  - busy = 0, progress = 0, mapped_pres = 0, done/aborted/key_err = 0
  - Reset mid-capture discards the shadow map and restores the identity committed map.
- States: IDLE, CAPTURE, COMMIT.
- IDLE:
  - key_pose and abort are ignored.
  - start: go to CAPTURE; clear assigned mask; progress = 0; timer = 0.
- CAPTURE (priority: abort > timeout > start > key):
  - abort: go to IDLE, pulse aborted; committed map unchanged; progress holds its last value until the next start.
  - Timeout (TIMEOUT_CYC>0 and timer == TIMEOUT_CYC-1): same as abort. The timer increments every CAPTURE cycle and clears on each accepted key.
  - start: restart the capture (clear mask, progress = 0, timer = 0); no pulse.
  - key_pose exactly one-hot at bit p with assigned[p]=0 (accepted key):
    - shadow[p] = progress[IDX_W-1:0], assigned[p] = 1, progress += 1.
    - If the new progress == NUM_KEYS, go to COMMIT.
  - key_pose at bit p with assigned[p]=1, or key_pose with more than one bit set (rejected key):
    - pulse key_err; no state change; the timer is not cleared.
  - key_pose all zero: no action.
- COMMIT: one cycle; committed map = shadow map; done pulses in the same cycle the new map_flat appears; go to IDLE. Inputs are ignored in this cycle.
- mapped_pres[L] = OR over p of (key_pres[p] AND committed[p]==L), registered, 1-cycle latency. It always uses the committed map, including during CAPTURE.
- Output pulses (done, aborted, key_err) are registered, last exactly one cycle, and are mutually exclusive.
- map_flat changes only in the COMMIT cycle or on reset.

Test Plan:
- Reset, then key_pres=8'b0000_0100 -> next cycle mapped_pres=8'b0000_0100; map_flat is identity (entry p = p).
- start, then single pulses on keys 7,6,5,4,3,2,1,0 -> progress counts 1..8, done pulses once, map_flat entry p = 7-p; key_pres=8'b0000_0001 -> mapped_pres=8'b1000_0000.
- Duplicate press of key 3 after it was accepted at progress 2 -> key_err 1 cycle; progress stays 3; shadow[3]=2. A key_pose of 8'b0001_0001 -> key_err; no change.
- 5 keys accepted, then abort asserted in the same cycle as a valid key_pose -> aborted pulse; the key is not taken; map_flat unchanged; busy=0.
- TIMEOUT_CYC=16, start, 1 key accepted, then idle -> aborted pulses 16 cycles after the accepted key; map unchanged.
- NUM_KEYS=5 (IDX_W=3): full capture in order 4,0,3,1,2 -> entries {1,3,4,2,0} for p=0..4. rst asserted during a second capture -> identity map restored, busy=0.

Source files
------------

// File: rtl/key_remap_ctrl.sv
// Purpose : capture a physical-to-logical key map (Nth accepted key becomes logical note N) and remap pressed keys.
// Latency : mapped_pres is 1 cycle after key_pres; the new map appears 1 cycle after the last accepted key (COMMIT).
// Backpr. : none; input pulses are consumed or ignored in the cycle they arrive.
//
// Ports:
//   sys_clk, rst        rising-edge clock, synchronous active-high reset
//   start / abort       one-cycle pulses: begin capture / cancel capture (esc)
//   key_pose / key_pres debounced press pulses / pressed levels, bit p = physical key p
//   mapped_pres         registered logical pressed vector through the committed map
//   map_flat            committed map, entry p at [p*IDX_W +: IDX_W]
//   busy, progress      capture/commit in flight; keys accepted so far in this capture
//   done/aborted/key_err one-cycle status pulses (commit / cancel or timeout / rejected key)
module key_remap_ctrl #(
    parameter int NUM_KEYS    = 8,
    parameter int IDX_W       = $clog2(NUM_KEYS),
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_KEYS-1:0]       key_pose,
    input  logic [NUM_KEYS-1:0]       key_pres,
    output logic [NUM_KEYS-1:0]       mapped_pres,
    output logic [NUM_KEYS*IDX_W-1:0] map_flat,
    output logic                      busy,
    output logic [IDX_W:0]            progress,
    output logic                      done,
    output logic                      aborted,
    output logic                      key_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_COMMIT  = 2'd2;

    localparam logic [IDX_W:0]    NK       = (IDX_W+1)'(NUM_KEYS);
    localparam logic [IDX_W:0]    PROG_ONE = (IDX_W+1)'(1);
    localparam logic [NUM_KEYS-1:0] POSE_ONE = NUM_KEYS'(1);
    localparam bit                TMO_EN   = (TIMEOUT_CYC > 0);
    // Wraps when the timeout is disabled, but is only compared when TMO_EN is set.
    localparam logic [31:0]       TMO_LAST = 32'(TIMEOUT_CYC) - 32'd1;

    logic [1:0]          state;
    logic [IDX_W-1:0]    committed [NUM_KEYS];
    logic [IDX_W-1:0]    shadow    [NUM_KEYS];
    logic [NUM_KEYS-1:0] assigned;
    logic [31:0]         timer;

    logic                pose_onehot;
    logic [IDX_W-1:0]    pose_idx;
    logic                key_accept;
    logic                key_reject;
    logic                tmo_hit;
    logic [IDX_W:0]      progress_inc;
    logic [NUM_KEYS-1:0] mapped_nxt;

    // Key decode: only a single fresh key is accepted; anything else non-zero is an error.
    always_comb begin
        pose_onehot = (key_pose != '0) && ((key_pose & (key_pose - POSE_ONE)) == '0);
        pose_idx    = '0;
        for (int p = 0; p < NUM_KEYS; p++) begin
            if (key_pose[p]) begin
                pose_idx = IDX_W'(p);
            end
        end
        key_accept   = pose_onehot && !assigned[pose_idx];
        key_reject   = (key_pose != '0) && !key_accept;
        tmo_hit      = TMO_EN && (timer == TMO_LAST);
        progress_inc = progress + PROG_ONE;
    end

    // Remap always goes through the committed map, so play continues unchanged during capture.
    always_comb begin
        mapped_nxt = '0;
        for (int l = 0; l < NUM_KEYS; l++) begin
            for (int p = 0; p < NUM_KEYS; p++) begin
                if (key_pres[p] && (committed[p] == IDX_W'(l))) begin
                    mapped_nxt[l] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        map_flat = '0;
        for (int p = 0; p < NUM_KEYS; p++) begin
            map_flat[p*IDX_W +: IDX_W] = committed[p];
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge sys_clk) begin
        done    <= 1'b0;
        aborted <= 1'b0;
        key_err <= 1'b0;
        if (rst) begin
            state       <= S_IDLE;
            assigned    <= '0;
            timer       <= '0;
            progress    <= '0;
            mapped_pres <= '0;
            for (int p = 0; p < NUM_KEYS; p++) begin
                committed[p] <= IDX_W'(p);
                shadow[p]    <= IDX_W'(p);
            end
        end else begin
            mapped_pres <= mapped_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CAPTURE;
                        assigned <= '0;
                        progress <= '0;
                        timer    <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (abort || tmo_hit) begin
                        // Committed map was never touched, so cancelling is just leaving.
                        state   <= S_IDLE;
                        aborted <= 1'b1;
                    end else if (start) begin
                        assigned <= '0;
                        progress <= '0;
                        timer    <= '0;
                    end else if (key_accept) begin
                        shadow[pose_idx]   <= progress[IDX_W-1:0];
                        assigned[pose_idx] <= 1'b1;
                        progress           <= progress_inc;
                        timer              <= '0;
                        if (progress_inc == NK) begin
                            state <= S_COMMIT;
                        end
                    end else begin
                        // Rejected presses do not count as activity for the timeout.
                        timer <= timer + 32'd1;
                        if (key_reject) begin
                            key_err <= 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    for (int p = 0; p < NUM_KEYS; p++) begin
                        committed[p] <= shadow[p];
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_remap_ctrl.sv
// Purpose : self-checking bench for key_remap_ctrl (8-key with timeout, 5-key without).
// Latency : expectations queued at each rising edge, compared on the following falling edge.
// Backpr. : n/a.
module tb_key_remap_ctrl;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic rst;

    logic        start0, abort0;
    logic [7:0]  pose0, pres0, mp0;
    logic [23:0] map0;
    logic        busy0, done0, ab0, ke0;
    logic [3:0]  prog0;

    logic        start1, abort1;
    logic [4:0]  pose1, pres1, mp1;
    logic [14:0] map1;
    logic        busy1, done1, ab1, ke1;
    logic [3:0]  prog1;

    key_remap_ctrl #(.NUM_KEYS(8), .TIMEOUT_CYC(16)) dut0 (
        .sys_clk(sys_clk), .rst(rst), .start(start0), .abort(abort0),
        .key_pose(pose0), .key_pres(pres0), .mapped_pres(mp0), .map_flat(map0),
        .busy(busy0), .progress(prog0), .done(done0), .aborted(ab0), .key_err(ke0)
    );

    key_remap_ctrl #(.NUM_KEYS(5), .TIMEOUT_CYC(0)) dut1 (
        .sys_clk(sys_clk), .rst(rst), .start(start1), .abort(abort1),
        .key_pose(pose1), .key_pres(pres1), .mapped_pres(mp1), .map_flat(map1),
        .busy(busy1), .progress(prog1), .done(done1), .aborted(ab1), .key_err(ke1)
    );

    typedef struct packed {
        logic        busy;
        logic [3:0]  prog;
        logic        done;
        logic        aborted;
        logic        key_err;
        logic [23:0] map;
        logic [7:0]  mp;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a capture is the ordered list of accepted keys;
    // the committed map is "position of key p in that list".
    bit m_cap  [2];
    bit m_cmt  [2];
    int m_cnt  [2];
    int m_idle [2];
    int m_order[2][8];
    int m_cmap [2][8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input int n, input int tmo, input logic r,
                              input logic s, input logic a, input logic [7:0] kp,
                              input logic [7:0] kr, output exp_t e);
        bit seen;
        int pos;
        e = '0;
        for (int p = 0; p < n; p++) begin
            if (kr[p]) e.mp[m_cmap[i][p]] = 1'b1;
        end
        if (r) begin
            m_cap[i] = 0; m_cmt[i] = 0; m_cnt[i] = 0; m_idle[i] = 0;
            for (int p = 0; p < 8; p++) m_cmap[i][p] = p;
            e.mp = '0;
        end else if (m_cmt[i]) begin
            for (int k = 0; k < n; k++) m_cmap[i][m_order[i][k]] = k;
            m_cmt[i] = 0;
            e.done = 1'b1;
        end else if (!m_cap[i]) begin
            if (s) begin
                m_cap[i] = 1; m_cnt[i] = 0; m_idle[i] = 0;
            end
        end else if (a || (tmo > 0 && m_idle[i] == tmo - 1)) begin
            m_cap[i] = 0;
            e.aborted = 1'b1;
        end else if (s) begin
            m_cnt[i] = 0; m_idle[i] = 0;
        end else begin
            seen = 0;
            pos  = 0;
            for (int k = 0; k < m_cnt[i]; k++) begin
                if (kp[m_order[i][k]]) seen = 1;
            end
            for (int p = 0; p < n; p++) begin
                if (kp[p]) pos = p;
            end
            if ($countones(kp) == 1 && !seen) begin
                m_order[i][m_cnt[i]] = pos;
                m_cnt[i]++;
                m_idle[i] = 0;
                if (m_cnt[i] == n) begin
                    m_cap[i] = 0;
                    m_cmt[i] = 1;
                end
            end else begin
                m_idle[i]++;
                if (kp != 8'h00) e.key_err = 1'b1;
            end
        end
        e.busy = m_cap[i] || m_cmt[i];
        e.prog = 4'(m_cnt[i]);
        for (int p = 0; p < n; p++) e.map[p*3 +: 3] = 3'(m_cmap[i][p]);
    endtask

    always @(posedge sys_clk) begin : model_proc
        exp_t e;
        model_step(0, 8, 16, rst, start0, abort0, pose0, pres0, e);
        q0.push_back(e);
        model_step(1, 5, 0, rst, start1, abort1, {3'b000, pose1}, {3'b000, pres1}, e);
        q1.push_back(e);
    end

    task automatic cmp(input string t, input exp_t e, input logic b, input logic [3:0] pg,
                       input logic d, input logic ab, input logic ke,
                       input logic [23:0] mf, input logic [7:0] mp);
        chk({t, "_busy"},     32'(b),  32'(e.busy));
        chk({t, "_progress"}, 32'(pg), 32'(e.prog));
        chk({t, "_done"},     32'(d),  32'(e.done));
        chk({t, "_aborted"},  32'(ab), 32'(e.aborted));
        chk({t, "_key_err"},  32'(ke), 32'(e.key_err));
        chk({t, "_map_flat"}, 32'(mf), 32'(e.map));
        chk({t, "_mapped"},   32'(mp), 32'(e.mp));
    endtask

    always @(negedge sys_clk) begin : monitor
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp("k8", e, busy0, prog0, done0, ab0, ke0, map0, mp0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("k5", e, busy1, prog1, done1, ab1, ke1, {9'b0, map1}, {3'b000, mp1});
        end
    end

    task automatic pulse0(input logic s, input logic a, input logic [7:0] kp);
        start0 = s; abort0 = a; pose0 = kp;
        @(negedge sys_clk);
        start0 = 1'b0; abort0 = 1'b0; pose0 = '0;
    endtask

    task automatic pulse1(input logic s, input logic a, input logic [4:0] kp);
        start1 = s; abort1 = a; pose1 = kp;
        @(negedge sys_clk);
        start1 = 1'b0; abort1 = 1'b0; pose1 = '0;
    endtask

    function automatic logic [7:0] rnd_pose(input int n);
        int r;
        r = $urandom_range(0, 99);
        if (r < 50)      return 8'h00;
        else if (r < 85) return 8'(1 << $urandom_range(0, n - 1));
        else             return 8'($urandom);
    endfunction

    initial begin : stim
        int n;
        int ord5[5];
        logic [7:0] tmp;
        ord5 = '{4, 0, 3, 1, 2};
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; pose0 = '0; pres0 = '0;
        start1 = 1'b0; abort1 = 1'b0; pose1 = '0; pres1 = '0;
        repeat (2) @(negedge sys_clk);

        // Reset state and identity remap
        rst   = 1'b0;
        pres0 = 8'b0000_0100;
        @(negedge sys_clk);
        chk("rst_map8",   32'(map0),  32'(24'o76543210));
        chk("rst_mp8",    32'(mp0),   32'h04);
        chk("rst_busy8",  32'(busy0), 32'd0);
        chk("rst_prog8",  32'(prog0), 32'd0);
        chk("rst_map5",   32'(map1),  32'(15'o43210));
        pres0 = '0;

        // Reverse order capture: 7..0
        pulse0(1'b1, 1'b0, 8'h00);
        for (int k = 7; k >= 0; k--) begin
            pulse0(1'b0, 1'b0, 8'(1 << k));
            chk("rev_progress", 32'(prog0), 32'(8 - k));
        end
        @(negedge sys_clk);
        chk("rev_done", 32'(done0), 32'd1);
        chk("rev_map",  32'(map0),  32'(24'o01234567));
        pres0 = 8'h01;
        @(negedge sys_clk);
        chk("rev_mapped", 32'(mp0), 32'h80);
        pres0 = '0;

        // Duplicate and multi-hot rejection, then complete the capture
        pulse0(1'b1, 1'b0, 8'h00);
        pulse0(1'b0, 1'b0, 8'h20);
        pulse0(1'b0, 1'b0, 8'h10);
        pulse0(1'b0, 1'b0, 8'h08);
        pulse0(1'b0, 1'b0, 8'h08);
        chk("dup_key_err",  32'(ke0),   32'd1);
        chk("dup_progress", 32'(prog0), 32'd3);
        pulse0(1'b0, 1'b0, 8'h11);
        chk("multi_key_err",  32'(ke0),   32'd1);
        chk("multi_progress", 32'(prog0), 32'd3);
        pulse0(1'b0, 1'b0, 8'h80);
        pulse0(1'b0, 1'b0, 8'h40);
        pulse0(1'b0, 1'b0, 8'h04);
        pulse0(1'b0, 1'b0, 8'h02);
        pulse0(1'b0, 1'b0, 8'h01);
        @(negedge sys_clk);
        chk("dup_map", 32'(map0), 32'(24'o34012567));

        // Abort in the same cycle as a valid key after 5 accepted
        pulse0(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) pulse0(1'b0, 1'b0, 8'(1 << k));
        pulse0(1'b0, 1'b1, 8'h20);
        chk("abort_pulse", 32'(ab0),   32'd1);
        chk("abort_busy",  32'(busy0), 32'd0);
        chk("abort_map",   32'(map0),  32'(24'o34012567));
        pulse0(1'b0, 1'b0, 8'h40);

        // Timeout after one accepted key
        pulse0(1'b1, 1'b0, 8'h00);
        pulse0(1'b0, 1'b0, 8'h01);
        n = 0;
        while (!ab0 && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        chk("tmo_cycles", 32'(n),    32'd16);
        chk("tmo_map",    32'(map0), 32'(24'o34012567));

        // 5-key capture in order 4,0,3,1,2
        pulse1(1'b1, 1'b0, 5'h00);
        foreach (ord5[k]) pulse1(1'b0, 1'b0, 5'(1 << ord5[k]));
        @(negedge sys_clk);
        chk("k5_done", 32'(done1), 32'd1);
        chk("k5_map",  32'(map1),  32'(15'o02431));

        // Reset in the middle of a capture
        pulse1(1'b1, 1'b0, 5'h00);
        pulse1(1'b0, 1'b0, 5'h04);
        pulse1(1'b0, 1'b0, 5'h01);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        chk("k5_rst_map",  32'(map1),  32'(15'o43210));
        chk("k5_rst_busy", 32'(busy1), 32'd0);
        chk("k5_rst_prog", 32'(prog1), 32'd0);
        chk("k8_rst_map",  32'(map0),  32'(24'o76543210));

        // Randomised traffic on both instances
        repeat (3000) begin
            rst    = ($urandom_range(0, 599) == 0);
            start0 = ($urandom_range(0, 149) == 0);
            abort0 = ($urandom_range(0, 199) == 0);
            pose0  = rnd_pose(8);
            pres0  = 8'($urandom);
            start1 = ($urandom_range(0, 99) == 0);
            abort1 = ($urandom_range(0, 199) == 0);
            tmp    = rnd_pose(5);
            pose1  = tmp[4:0];
            tmp    = 8'($urandom);
            pres1  = tmp[4:0];
            @(negedge sys_clk);
        end
        rst = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; pose0 = '0; pres0 = '0;
        start1 = 1'b0; abort1 = 1'b0; pose1 = '0; pres1 = '0;
        repeat (3) @(negedge sys_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
